// File: rtl/vr_hs_bridge.sv
// Valid/ready to req/ack bridge: DEPTH-entry FIFO feeding a 4-phase or 2-phase
// handshake launcher, with an optional ack synchroniser.
module vr_hs_bridge #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int PHASE    = 0,
  parameter int ACK_SYNC = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     valid,
  output logic                     ready,
  input  logic [WIDTH-1:0]         data_in,
  output logic                     req,
  input  logic                     ack,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             ack_s, push, done, launch;

  generate
    if (ACK_SYNC == 0) begin : g_nosync
      assign ack_s = ack;
    end else begin : g_sync
      logic [ACK_SYNC-1:0] sync_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else begin
          sync_q[0] <= ack;
          for (int i = 1; i < ACK_SYNC; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign ack_s = sync_q[ACK_SYNC-1];
    end
  endgenerate

  // done: the current slot is free for a new launch this cycle
  always_comb begin
    done = 1'b0;
    case (state)
      IDLE:    done = 1'b1;
      REQ:     done = (PHASE != 0) && (ack_s == req);
      RELEASE: done = !ack_s;
      default: done = 1'b0;
    endcase
  end

  assign push      = valid && ready;
  assign launch    = done && en && (count != '0);
  assign count_nxt = count + CW'(push) - CW'(launch);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req      <= 1'b0;
      data_out <= '0;
      count    <= '0;
      ready    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      count <= count_nxt;
      // ready follows next-cycle occupancy so a full FIFO is never overwritten
      ready <= (count_nxt < CW'(DEPTH));
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (launch) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
        req      <= (PHASE != 0) ? ~req : 1'b1;
        state    <= REQ;
      end else begin
        case (state)
          REQ: begin
            if (PHASE == 0) begin
              if (ack_s) begin
                req   <= 1'b0;
                state <= RELEASE;
              end
            end else if (done) begin
              state <= IDLE;
            end
          end
          RELEASE: if (!ack_s) state <= IDLE;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_vr_hs_bridge.sv
// Scoreboard bench for vr_hs_bridge: three instances (4-phase, 2-phase,
// 4-phase with 2-flop ack sync) driven by directed vectors.
module tb_vr_hs_bridge;
  logic       clk, rst;
  logic       en [3], valid [3], ready [3], req [3], ack [3], preq [3];
  logic [7:0] din [3], dout [3];
  logic [2:0] cnt [3];
  logic       auto_ack [3];
  logic [7:0] q0 [$], q1 [$], q2 [$];
  int         checks = 0, failures = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    vr_hs_bridge #(.WIDTH(8), .DEPTH(4), .PHASE(g == 1 ? 1 : 0),
                   .ACK_SYNC(g == 2 ? 2 : 0)) u_dut (
      .clk(clk), .rst(rst), .en(en[g]), .valid(valid[g]), .ready(ready[g]),
      .data_in(din[g]), .req(req[g]), .ack(ack[g]), .data_out(dout[g]),
      .count(cnt[g]));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // receiver: ack mirrors req one cycle later, or is held low
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) ack[i] <= 1'b0;
      else     ack[i] <= auto_ack[i] ? req[i] : 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic void qpush(input int i, input logic [7:0] v);
    case (i)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  task automatic mon_check(input int i, input logic [7:0] d);
    int sz;
    logic [7:0] e;
    sz = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_launch dut%0d actual=%0h required=none", i, d);
    end else begin
      case (i)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("launch_data_dut%0d", i), {24'h0, d}, {24'h0, e});
    end
  endtask

  // monitor: a launch is a req rise (4-phase) or any req toggle (2-phase)
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst && ((i == 1) ? (req[i] != preq[i]) : (req[i] && !preq[i])))
        mon_check(i, dout[i]);
      preq[i] <= req[i];
    end
  end

  task automatic push(input int i, input logic [7:0] v);
    int n = 0;
    @(negedge clk);
    valid[i] = 1'b1; din[i] = v;
    while (!ready[i] && n < 200) begin
      @(negedge clk); n++;
    end
    if (!ready[i]) begin
      checks++; failures++;
      $display("FAIL push_timeout dut%0d actual=notready required=ready", i);
      valid[i] = 1'b0;
      return;
    end
    qpush(i, v);
    @(posedge clk); #1;
    valid[i] = 1'b0;
  endtask

  initial begin
    int pr, toggles, bad;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b1; valid[i] = 1'b0; din[i] = 8'h00; auto_ack[i] = 1'b1; preq[i] = 1'b0;
    end
    #2 rst = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_req%0d", i), req[i], 0);
      chk($sformatf("rst_count%0d", i), cnt[i], 0);
      chk($sformatf("rst_ready%0d", i), ready[i], 0);
      chk($sformatf("rst_dout%0d", i), dout[i], 0);
    end
    @(negedge clk); rst = 1'b0;
    tick;
    for (int i = 0; i < 3; i++) chk($sformatf("post_rst_ready%0d", i), ready[i], 1);
    repeat (3) tick;
    for (int i = 0; i < 3; i++) chk($sformatf("idle_req%0d", i), req[i], 0);

    // 4-phase single word then one more, with and without ack sync
    @(negedge clk);
    valid[0] = 1'b1; valid[2] = 1'b1; din[0] = 8'hA5; din[2] = 8'hA5;
    qpush(0, 8'hA5); qpush(2, 8'hA5);
    tick;                                   // N
    chk("n_count0", cnt[0], 1);
    chk("n_req0", req[0], 0);
    din[0] = 8'h5A; din[2] = 8'h5A; qpush(0, 8'h5A); qpush(2, 8'h5A);
    tick;                                   // N+1
    valid[0] = 1'b0; valid[2] = 1'b0;
    chk("n1_req0", req[0], 1);
    chk("n1_dout0", dout[0], 8'hA5);
    chk("n1_count0", cnt[0], 1);
    chk("n1_req2", req[2], 1);
    tick; tick;                             // N+3
    chk("n3_req0_fall", req[0], 0);
    chk("n3_req2", req[2], 1);
    tick;                                   // N+4
    chk("n4_req2", req[2], 1);
    tick;                                   // N+5
    chk("n5_req0_relaunch", req[0], 1);
    chk("n5_dout0", dout[0], 8'h5A);
    chk("n5_req2_fall", req[2], 0);
    repeat (3) tick;                        // N+8
    chk("n8_req2", req[2], 0);
    tick;                                   // N+9
    chk("n9_req2_relaunch", req[2], 1);
    chk("n9_dout2", dout[2], 8'h5A);
    chk("n9_count2", cnt[2], 0);
    repeat (20) tick;
    chk("p0_drain_count0", cnt[0], 0);
    chk("p0_drain_req0", req[0], 0);
    chk("p0_drain_req2", req[2], 0);

    // fill and backpressure with ack held low
    auto_ack[0] = 1'b0;
    fork
      begin
        for (int v = 1; v <= 6; v++) push(0, 8'(v));
      end
      begin
        repeat (12) tick;
        chk("full_count", cnt[0], 4);
        chk("full_ready", ready[0], 0);
        chk("full_dout", dout[0], 8'h01);
        chk("full_req", req[0], 1);
        auto_ack[0] = 1'b1;
      end
    join
    repeat (60) tick;
    chk("fill_drain_count", cnt[0], 0);

    // en gating during an in-flight transfer
    push(0, 8'h10);
    tick;
    chk("en_launch_req", req[0], 1);
    chk("en_launch_dout", dout[0], 8'h10);
    en[0] = 1'b0;
    push(0, 8'h11); push(0, 8'h12); push(0, 8'h13);
    repeat (10) tick;
    chk("en_hold_count", cnt[0], 3);
    chk("en_hold_req", req[0], 0);
    chk("en_hold_dout", dout[0], 8'h10);
    @(negedge clk); en[0] = 1'b1;
    tick;
    chk("en_resume_req", req[0], 1);
    chk("en_resume_dout", dout[0], 8'h11);
    chk("en_resume_count", cnt[0], 2);
    repeat (40) tick;

    // 2-phase streaming: one toggle every 2 clocks
    fork
      begin
        for (int v = 0; v < 8; v++) push(1, 8'(8'h20 + v));
      end
      begin
        pr = req[1];
        for (int k = 0; k < 40 && req[1] == pr; k++) tick;
        chk("p1_first_toggle", (req[1] != pr) ? 1 : 0, 1);
        pr = req[1]; toggles = 0; bad = 0;
        for (int k = 1; k <= 14; k++) begin
          tick;
          if (req[1] != pr) toggles++;
          if ((req[1] != pr) != (k % 2 == 0)) bad++;
          pr = req[1];
        end
        chk("p1_toggles", toggles, 7);
        chk("p1_spacing_errs", bad, 0);
      end
    join
    repeat (20) tick;
    chk("p1_drain_count", cnt[1], 0);

    // reset in the middle of a transfer
    auto_ack[0] = 1'b0;
    push(0, 8'h77);
    tick;
    chk("mid_req_before", req[0], 1);
    #2 rst = 1'b1; #1;
    chk("mid_rst_req", req[0], 0);
    chk("mid_rst_count", cnt[0], 0);
    chk("mid_rst_ready", ready[0], 0);
    q0.delete(); q1.delete(); q2.delete();
    @(negedge clk); rst = 1'b0; auto_ack[0] = 1'b1;
    tick;
    chk("mid_post_ready", ready[0], 1);
    repeat (5) tick;
    chk("mid_post_req", req[0], 0);

    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    chk("q2_empty", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
